fpu_iter_ctrl: RTL and testbench

Sequencing controller for the FPU's iterative divide/square-root datapath, which is built from enable-gated, async-reset data registers. It accepts one operation per valid/ready handshake and drives the enables of three register groups: operand load, per-iteration partial remainder/quotient, and result capture. It also provides an iteration index to the datapath and presents the finished result with a valid/ready output handshake.

---
 rtl/fpu_iter_ctrl.sv | 62 ++++++
 tb/tb_fpu_iter_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_iter_ctrl.sv
// fpu_iter_ctrl: sequencer for the iterative divide/sqrt datapath (operand load, iterate, capture, hand off).
module fpu_iter_ctrl #(
  parameter int ITERS_DIV  = 26,
  parameter int ITERS_SQRT = 25,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             abort,
  output logic             ld_en,
  output logic             it_en,
  output logic             first_it,
  output logic [CNT_W-1:0] iter_idx,
  output logic             op_q,
  output logic             res_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2, DONE = 2'd3;
  localparam logic [CNT_W-1:0] LAST_DIV  = CNT_W'(ITERS_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_SQRT = CNT_W'(ITERS_SQRT - 1);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic             op_d, accept, in_iter, at_last;
  // Enables are gated by rst so nothing fires while the datapath is held in reset.
  always_comb begin
    last      = op_q ? LAST_SQRT : LAST_DIV;
    in_iter   = state_q == ITER;
    at_last   = cnt_q == last;
    in_ready  = ~rst & ~abort & (state_q == IDLE | (state_q == DONE & out_ready));
    accept    = in_valid & in_ready;
    ld_en     = accept;
    it_en     = ~rst & ~abort & in_iter;
    res_en    = ~rst & ~abort & state_q == FIN;
    first_it  = ~rst & in_iter & cnt_q == '0;
    iter_idx  = in_iter ? cnt_q : '0;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    op_d      = accept ? in_op : op_q;
    cnt_d     = (abort | accept | ~in_iter | at_last) ? '0 : cnt_q + 1'b1;
    state_d   = abort              ? IDLE :
                accept             ? ITER :
                in_iter            ? (at_last ? FIN : ITER) :
                state_q == FIN     ? DONE :
                state_q == DONE    ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
endmodule

// File: tb/tb_fpu_iter_ctrl.sv
// tb_fpu_iter_ctrl: directed checks of the divide/sqrt sequencer with default parameters (26/25 iterations).
module tb_fpu_iter_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b1, in_op = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic       in_ready, ld_en, it_en, first_it, op_q, res_en, out_valid, busy;
  logic [4:0] iter_idx;
  int         n_chk = 0, n_fail = 0;

  fpu_iter_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .abort(abort), .ld_en(ld_en), .it_en(it_en), .first_it(first_it), .iter_idx(iter_idx),
    .op_q(op_q), .res_en(res_en), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expects to start in the first ITER cycle; ends positioned in the first DONE cycle.
  task automatic iters(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("it_en", it_en, 1);
      chk("iter_idx", iter_idx, i);
      chk("first_it", first_it, i == 0);
      chk("res_en_iter", res_en, 0);
      chk("busy_iter", busy, 1);
      tick();
    end
    #1;
    chk("res_en_fin", res_en, 1);
    chk("it_en_fin", it_en, 0);
    chk("out_valid_fin", out_valid, 0);
    tick();
    #1;
    chk("out_valid_done", out_valid, 1);
    chk("res_en_done", res_en, 0);
  endtask

  initial begin
    // Reset: in_valid is high but nothing may be enabled.
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_q", op_q, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_iter_idx", iter_idx, 0);
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    // Divide: accept at cycle 0, 26 iterations, FIN at 27, DONE at 28.
    in_valid = 1'b1; in_op = 1'b0;
    #1;
    chk("div_in_ready", in_ready, 1);
    chk("div_ld_en", ld_en, 1);
    tick();
    in_valid = 1'b0;
    iters(26);
    chk("div_op_q", op_q, 0);
    tick();
    #1;
    chk("div_hold_valid", out_valid, 1);
    chk("div_hold_res_en", res_en, 0);
    out_ready = 1'b1;
    #1;
    chk("div_done_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("div_idle_busy", busy, 0);
    chk("div_idle_valid", out_valid, 0);

    // Sqrt with a stray in_valid during ITER and out_ready held low for 10 DONE cycles.
    in_valid = 1'b1; in_op = 1'b1;
    #1;
    chk("sq_ld_en", ld_en, 1);
    tick();
    for (int i = 0; i < 25; i++) begin
      in_valid = (i == 5); in_op = 1'b0;
      #1;
      chk("sq_it_en", it_en, 1);
      chk("sq_iter_idx", iter_idx, i);
      chk("sq_ld_en_iter", ld_en, 0);
      chk("sq_in_ready_iter", in_ready, 0);
      chk("sq_op_q", op_q, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("sq_res_en", res_en, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("sq_hold_valid", out_valid, 1);
      chk("sq_hold_res_en", res_en, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("sq_in_ready_done", in_ready, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("sq_valid_drop", out_valid, 0);

    // Back-to-back divides: accepts at cycles 0, 28, 56.
    in_valid = 1'b1; in_op = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 84; c++) begin
      automatic int m = c % 28;
      #1;
      chk("b2b_ld_en", ld_en, m == 0);
      chk("b2b_it_en", it_en, m >= 1 && m <= 26);
      chk("b2b_res_en", res_en, m == 27);
      chk("b2b_out_valid", out_valid, m == 0 && c > 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("b2b_last_valid", out_valid, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("b2b_idle", busy, 0);

    // Abort at iter_idx 10, then a full rerun.
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("ab_iter_idx", iter_idx, i);
      tick();
    end
    abort = 1'b1;
    #1;
    chk("ab_it_en", it_en, 0);
    chk("ab_idx10", iter_idx, 10);
    chk("ab_in_ready", in_ready, 0);
    tick();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ab_busy", busy, 0);
      chk("ab_res_en", res_en, 0);
      chk("ab_out_valid", out_valid, 0);
      chk("ab_it_en_after", it_en, 0);
      tick();
    end
    in_valid = 1'b1;
    #1;
    chk("ab_re_ld_en", ld_en, 1);
    tick();
    in_valid = 1'b0;
    iters(26);

    // Abort in DONE beats both out_ready and in_valid.
    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("abd_in_ready", in_ready, 0);
    chk("abd_ld_en", ld_en, 0);
    chk("abd_valid", out_valid, 1);
    tick();
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("abd_busy", busy, 0);
    chk("abd_valid_drop", out_valid, 0);

    // Reset asserted mid-ITER clears everything immediately.
    in_valid = 1'b1; in_op = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("mr_it_en", it_en, 1);
    chk("mr_iter_idx", iter_idx, 3);
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_it_en_rst", it_en, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_op_q", op_q, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mr_busy_after", busy, 0);
      chk("mr_it_en_after", it_en, 0);
      chk("mr_res_en_after", res_en, 0);
      chk("mr_valid_after", out_valid, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
